// File: rtl/watch_time_counter.sv
// watch_time_counter: binary time-of-day counter driven by a 1 Hz prescaler.
// Keeps seconds, minutes and a 5-bit 24-hour field. Manual set pulses step
// single fields without carry.
// Optional build macro WATCH_12H_EN: hour is presented as 1..12 with a pm flag.
// When the macro is undefined, hour is 0..23 and pm is tied low.

module watch_time_counter #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       clear,
  input  logic       inc_sec,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [6:0] sec,
  output logic [6:0] min,
  output logic [6:0] hour,
  output logic       pm,
  output logic       tick_1hz
);

  localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] prescaler;
  logic [6:0]    sec_q;
  logic [6:0]    min_q;
  logic [4:0]    hour24;
  logic          tick_q;

  logic          wrap;
  logic          any_inc;
  logic [6:0]    sec_next;
  logic [6:0]    min_next;
  logic [4:0]    hour_next;

  // A wrap only happens while running; a frozen prescaler never ticks.
  assign wrap    = run && (prescaler == PRE_MAX);
  assign any_inc = inc_sec | inc_min | inc_hour;

  // Field-local wrapped increments, shared by manual set and tick advance.
  assign sec_next  = (sec_q == 7'd59)  ? 7'd0 : sec_q + 7'd1;
  assign min_next  = (min_q == 7'd59)  ? 7'd0 : min_q + 7'd1;
  assign hour_next = (hour24 == 5'd23) ? 5'd0 : hour24 + 5'd1;

  // Prescaler, tick and time fields; clear beats manual set, manual set beats the tick advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      sec_q     <= 7'd0;
      min_q     <= 7'd0;
      hour24    <= 5'd0;
      tick_q    <= 1'b0;
    end else if (clear) begin
      prescaler <= '0;
      sec_q     <= 7'd0;
      min_q     <= 7'd0;
      hour24    <= 5'd0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (run) begin
        prescaler <= wrap ? '0 : prescaler + PW'(1);
      end
      if (any_inc) begin
        if (inc_sec) begin
          sec_q <= sec_next;
        end
        if (inc_min) begin
          min_q <= min_next;
        end
        if (inc_hour) begin
          hour24 <= hour_next;
        end
      end else if (wrap) begin
        sec_q <= sec_next;
        if (sec_q == 7'd59) begin
          min_q <= min_next;
          if (min_q == 7'd59) begin
            hour24 <= hour_next;
          end
        end
      end
    end
  end

  assign sec      = sec_q;
  assign min      = min_q;
  assign tick_1hz = tick_q;

`ifdef WATCH_12H_EN
  // 12-hour presentation: midnight/noon show as 12, afternoon hours fold down by 12.
  always_comb begin
    hour = {2'b00, hour24};
    if (hour24 == 5'd0) begin
      hour = 7'd12;
    end else if (hour24 > 5'd12) begin
      hour = {2'b00, hour24 - 5'd12};
    end
  end

  assign pm = (hour24 >= 5'd12);
`else
  assign hour = {2'b00, hour24};
  assign pm   = 1'b0;
`endif

endmodule

// File: tb/tb_watch_time_counter.sv
// tb_watch_time_counter: directed stimulus with a cycle-stamped scoreboard.
// Stimulus pushes expected states tagged with the cycle they must appear in;
// a monitor samples on every falling edge and pops matching entries.

module tb_watch_time_counter;

  localparam int CLK_HZ = 4;

  logic       clk;
  logic       reset;
  logic       run;
  logic       clear;
  logic       inc_sec;
  logic       inc_min;
  logic       inc_hour;
  logic [6:0] sec;
  logic [6:0] min;
  logic [6:0] hour;
  logic       pm;
  logic       tick_1hz;

  typedef struct {
    int    cycle;
    int    s;
    int    m;
    int    h24;
    bit    tick;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc          = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  watch_time_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .clear    (clear),
    .inc_sec  (inc_sec),
    .inc_min  (inc_min),
    .inc_hour (inc_hour),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .pm       (pm),
    .tick_1hz (tick_1hz)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int exp_hour(input int h24);
`ifdef WATCH_12H_EN
    if (h24 == 0) return 12;
    if (h24 > 12) return h24 - 12;
    return h24;
`else
    return h24;
`endif
  endfunction

  function automatic bit exp_pm(input int h24);
`ifdef WATCH_12H_EN
    return (h24 >= 12);
`else
    return 1'b0;
`endif
  endfunction

  // Queue an expected state for the falling edge 'delta' edges from now.
  task automatic expect_at(input int delta, input string name, input int s,
                           input int m, input int h24, input bit t);
    exp_t e;
    e.cycle = cyc + delta;
    e.s     = s;
    e.m     = m;
    e.h24   = h24;
    e.tick  = t;
    e.name  = name;
    q.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    int  eh;
    bit  ep;
    bit  bad;
    eh  = exp_hour(e.h24);
    ep  = exp_pm(e.h24);
    bad = (e.cycle != cyc) || (int'(sec) != e.s) || (int'(min) != e.m) ||
          (int'(hour) != eh) || (pm != ep) || (tick_1hz != e.tick);
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("[TB] FAIL %s @cyc %0d (want cyc %0d): got %0d:%0d:%0d pm=%0d tick=%0d, expected %0d:%0d:%0d pm=%0d tick=%0d",
               e.name, cyc, e.cycle, hour, min, sec, pm, tick_1hz,
               eh, e.m, e.s, ep, e.tick);
    end
  endtask

  // Monitor: samples away from the rising edge and retires due entries.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      while (q.size() > 0 && q[0].cycle <= cyc) begin
        e = q.pop_front();
        check_output(e);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit cl, input bit is,
                                input bit im, input bit ih);
    run      = r;
    clear    = cl;
    inc_sec  = is;
    inc_min  = im;
    inc_hour = ih;
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    reset = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0);
    wait_cycles(2);
    expect_at(1, "reset_state", 0, 0, 0, 0);
    wait_cycles(1);

    // Reset release with run: ticks at edges 4, 8, 12.
    reset = 1'b0;
    apply_stimulus(1, 0, 0, 0, 0);
    expect_at(1,  "first_edge",  0, 0, 0, 0);
    expect_at(4,  "tick1",       1, 0, 0, 1);
    expect_at(5,  "tick1_end",   1, 0, 0, 0);
    expect_at(8,  "tick2",       2, 0, 0, 1);
    expect_at(12, "tick3",       3, 0, 0, 1);
    wait_cycles(12);

    // Clear while stopped, then load 23:59:58 using simultaneous pulses.
    apply_stimulus(0, 1, 0, 0, 0);
    expect_at(1, "clear_stopped", 0, 0, 0, 0);
    wait_cycles(1);
    for (int i = 0; i < 59; i++) begin
      apply_stimulus(0, 0, i < 58, i < 59, i < 23);
      wait_cycles(1);
    end
    apply_stimulus(1, 0, 0, 0, 0);
    expect_at(1, "loaded_235958",   58, 59, 23, 0);
    expect_at(4, "tick_235959",     59, 59, 23, 1);
    expect_at(8, "rollover_000000",  0,  0,  0, 1);
    wait_cycles(8);

    // Freeze at prescaler 2 for 10 cycles, then resume.
    wait_cycles(2);
    apply_stimulus(0, 0, 0, 0, 0);
    expect_at(5,  "frozen_mid", 0, 0, 0, 0);
    expect_at(10, "frozen_end", 0, 0, 0, 0);
    wait_cycles(10);
    apply_stimulus(1, 0, 0, 0, 0);
    expect_at(1, "resume_no_tick", 0, 0, 0, 0);
    expect_at(2, "resume_tick",    1, 0, 0, 1);
    wait_cycles(2);

    // Bring sec to 10, then inc_sec coincident with a tick.
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(0, 0, 1, 0, 0);
      wait_cycles(1);
    end
    apply_stimulus(1, 0, 0, 0, 0);
    expect_at(1, "sec_loaded_10", 10, 0, 0, 0);
    wait_cycles(3);
    apply_stimulus(1, 0, 1, 0, 0);
    expect_at(1, "inc_over_tick", 11, 0, 0, 1);
    wait_cycles(1);
    apply_stimulus(1, 0, 0, 0, 0);
    expect_at(1, "after_inc_tick", 11, 0, 0, 0);
    wait_cycles(1);

    // inc_min wraps 59 -> 0 without touching hour.
    for (int i = 0; i < 60; i++) begin
      apply_stimulus(0, 0, 0, 1, 0);
      if (i == 58) expect_at(1, "min_at_59",  11, 59, 0, 0);
      if (i == 59) expect_at(1, "min_wrap_0", 11,  0, 0, 0);
      wait_cycles(1);
    end

    // Load 05:06:07, then clear coincident with a tick.
    apply_stimulus(0, 1, 0, 0, 0);
    expect_at(1, "clear_before_load", 0, 0, 0, 0);
    wait_cycles(1);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(0, 0, i < 7, i < 6, i < 5);
      wait_cycles(1);
    end
    apply_stimulus(1, 0, 0, 0, 0);
    expect_at(1, "loaded_050607", 7, 6, 5, 0);
    wait_cycles(3);
    apply_stimulus(1, 1, 0, 0, 0);
    expect_at(1, "clear_over_tick", 0, 0, 0, 0);
    wait_cycles(1);
    apply_stimulus(1, 0, 0, 0, 0);
    expect_at(3, "post_clear_quiet", 0, 0, 0, 0);
    expect_at(4, "post_clear_tick",  1, 0, 0, 1);
    wait_cycles(4);

    // Load 01:02:03, then assert reset just after a rising edge.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, i < 2, i < 2, i < 1);
      wait_cycles(1);
    end
    apply_stimulus(1, 0, 0, 0, 0);
    expect_at(1, "loaded_010203_a", 3, 2, 1, 0);
    expect_at(2, "loaded_010203_b", 3, 2, 1, 0);
    wait_cycles(2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    expect_at(1, "async_reset", 0, 0, 0, 0);
    wait_cycles(1);
    reset = 1'b0;
    expect_at(3, "post_reset_quiet", 0, 0, 0, 0);
    expect_at(4, "post_reset_tick",  1, 0, 0, 1);
    wait_cycles(4);

    // Drain: anything still queued was never observed.
    wait_cycles(2);
    while (q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: got no sample, expected check at cyc %0d", q[0].name, q[0].cycle);
      void'(q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/watch_time_counter.md
# watch_time_counter

Binary time-of-day counter for the watch datapath. Divides the system clock to a 1 Hz tick and maintains seconds, minutes and hours as 7-bit binary fields. Each field feeds a downstream 7-bit binary-to-BCD converter (ONES/TENS) ahead of the display. Also accepts pre-debounced set pulses for manual time adjustment.

## Interface
Parameters:
- CLK_HZ, 100_000_000, input clock frequency; one tick per CLK_HZ cycles; legal range ≥ 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- run  in  1  level; 1 = prescaler counts and time advances; 0 = prescaler and time frozen.
- clear  in  1  sync single-cycle pulse; zeroes time and prescaler.
- inc_sec  in  1  sync single-cycle pulse; seconds +1 with wrap, no carry.
- inc_min  in  1  sync single-cycle pulse; minutes +1 with wrap, no carry.
- inc_hour  in  1  sync single-cycle pulse; hours +1 with wrap.
- sec  out  7  seconds 0–59, binary.
- min  out  7  minutes 0–59, binary.
- hour  out  7  hours, binary; 0–23, or 1–12 under WATCH_12H_EN.
- pm  out  1  PM flag under WATCH_12H_EN; constant 0 otherwise.
- tick_1hz  out  1  registered one-cycle pulse on each prescaler wrap.

## Operation
- Prescaler: width $clog2(CLK_HZ). Counts 0..CLK_HZ-1 while run=1, then wraps to 0. Held at its current value while run=0.
- Tick: on the edge where prescaler==CLK_HZ-1 and run=1:
  - prescaler<=0;
  - tick_1hz<=1 for exactly one cycle;
  - time advances by one second.
- Advance:
  - sec 59→0 carries to min.
  - min 59→0 (with carry in) carries to hour.
  - Internal hour24 23→0 with no further carry.
- Manual set:
  - Each inc_* increments only its own field, with field-local wrap (59→0, 23→0). Never carries.
  - Several inc_* in the same cycle are all applied independently.
- Priority per cycle: reset > clear > any inc_* > tick advance.
  - In a cycle where any inc_* is high, the tick's time advance is discarded.
  - The prescaler still wraps and tick_1hz still pulses in that cycle.
- clear:
  - Sets sec/min/hour24 = 0 and prescaler = 0.
  - Suppresses tick_1hz that cycle.
  - Effective regardless of run.
- Output arithmetic:
  - Internal hour24 is 5 bits, zero-extended to 7 bits.
  - All outputs are always ≤ 59, so they are valid inputs to the 7-bit BCD converter.
  - Out-of-range values are unreachable.

## Timing
- Reset values: sec=0, min=0, hour=0 (12 with WATCH_12H_EN), pm=0, tick_1hz=0, prescaler=0.
- After reset deasserts with run=1, the first tick_1hz pulse and sec=1 appear together, CLK_HZ rising edges later. Subsequent ticks follow every CLK_HZ cycles.
- Latency:
  - inc_*/clear take effect on the same edge that samples them; outputs change the next cycle.
  - sec/min/hour update on the same edge that asserts tick_1hz.
- Carry chain resolves in one cycle. 23:59:59 → 00:00:00 on a single tick edge.
- run deassert: the prescaler freezes mid-count. On re-assert, counting resumes from the held value; no phase reset.
- Reset mid-count: all state returns to reset values asynchronously. A pending tick is lost.
- Outputs are registers, or pure decodes of registers (12h conversion); glitch-free with respect to inputs.

## Configuration
- WATCH_12H_EN defined:
  - hour is a combinational decode of hour24: 0→12, 1–12→same, 13–23→hour24-12.
  - pm = (hour24 ≥ 12).
  - inc_hour still steps hour24 through all 24 values, so pm toggles at 11→12.
- WATCH_12H_EN undefined:
  - hour = hour24 (0–23).
  - pm tied to 0.
- Counting and carry logic are identical in both builds.

## Test plan
All with CLK_HZ=4.
- Reset release, run=1 → tick_1hz high on cycles 4, 8, 12; sec=1, 2, 3 aligned with each pulse; min=0, hour=0.
- Load 23:59:58 via inc_* pulses, run=1, two ticks → 23:59:59 then 00:00:00 in one edge. Under WATCH_12H_EN: 11:59:59 pm=1 → 12:00:00 pm=0.
- run=0 at prescaler=2 for 10 cycles, then run=1 → no tick while frozen; next tick exactly 2 cycles after re-assert.
- inc_sec coincident with tick at sec=10 → sec=11 (not 12), tick_1hz=1. inc_min at min=59 → min=0, hour unchanged.
- clear coincident with tick at 05:06:07 → 00:00:00, tick_1hz=0, next tick 4 cycles later.
- reset asserted mid-count at 01:02:03 → outputs are reset values before the next clk edge; counting restarts from prescaler=0 after release.
